fsk_demod: RTL

- FSK receiver: recovers the tone from a 1-bit FSK square wave arriving on a user GPIO pad and measures the half-period between edges to tell mark from space.
- Deframes UART-style characters (1 start, 8 data LSB-first, 1 stop) and presents bytes on a valid/ready interface to the user-project logic.
- Counterpart to the FSK transmitter path; used for loopback and pad-to-pad tests.

---
 rtl/fsk_pkg.sv | 18 +
 rtl/fsk_tone_detect.sv | 57 +++++
 rtl/fsk_demod.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/fsk_pkg.sv
// Shared types and default constants for the FSK receive path.
// Imported by the tone detector and the deframer.
package fsk_pkg;

    localparam int CNT_W_DEF      = 12;
    localparam int THRESH_DEF     = 40;
    localparam int MAX_HALF_DEF   = 200;
    localparam int BIT_CYCLES_DEF = 1000;
    localparam int DATA_BITS      = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } fsk_state_e;

endpackage

// File: rtl/fsk_tone_detect.sv
// Recovers the tone from the pad square wave by timing the half-period between
// synchronised edges; also flags carrier presence.
module fsk_tone_detect
    import fsk_pkg::*;
#(
    parameter int CNT_W    = CNT_W_DEF,
    parameter int THRESH   = THRESH_DEF,
    parameter int MAX_HALF = MAX_HALF_DEF
) (
    input  logic clk,
    input  logic resetb,
    input  logic fsk_in,
    output logic tone,
    output logic carrier
);

    logic             sync_1;
    logic             sync_2;
    logic             sync_prev;
    logic             edge_evt;
    logic [CNT_W-1:0] half_cnt;

    // Either polarity of transition ends a half-period.
    assign edge_evt = sync_2 ^ sync_prev;

    // NOTE: every register here uses <= so all flops sample the pre-edge
    // values together; blocking assignments would collapse the synchroniser.
    always_ff @(posedge clk) begin
        if (!resetb) begin
            sync_1    <= 1'b0;
            sync_2    <= 1'b0;
            sync_prev <= 1'b0;
            half_cnt  <= '0;
            tone      <= 1'b1;
            carrier   <= 1'b0;
        end else begin
            sync_1    <= fsk_in;
            sync_2    <= sync_1;
            sync_prev <= sync_2;
            if (edge_evt) begin
                half_cnt <= CNT_W'(1);
                tone     <= (half_cnt < CNT_W'(THRESH));
                carrier  <= 1'b1;
            end else begin
                if (half_cnt != '1) begin
                    half_cnt <= half_cnt + CNT_W'(1);
                end
                // Too long without an edge: fall back to the idle (mark) tone.
                if (half_cnt >= CNT_W'(MAX_HALF)) begin
                    carrier <= 1'b0;
                    tone    <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/fsk_demod.sv
// FSK receiver: tone detection feeding a UART-style deframer (1 start, 8 data
// LSB-first, 1 stop) with a valid/ready byte output.
module fsk_demod
    import fsk_pkg::*;
#(
    parameter int CNT_W      = CNT_W_DEF,
    parameter int THRESH     = THRESH_DEF,
    parameter int MAX_HALF   = MAX_HALF_DEF,
    parameter int BIT_CYCLES = BIT_CYCLES_DEF
) (
    input  logic       clk,
    input  logic       resetb,
    input  logic       en,
    input  logic       fsk_in,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       tone,
    output logic       carrier,
    output logic       frame_err,
    output logic       overrun
);

    localparam int               IDX_W     = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] BIT_LOAD  = CNT_W'(BIT_CYCLES);
    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(BIT_CYCLES / 2);

    fsk_state_e           state;
    fsk_state_e           state_nxt;
    logic [CNT_W-1:0]     timer;
    logic [CNT_W-1:0]     timer_nxt;
    logic [IDX_W-1:0]     bit_idx;
    logic [IDX_W-1:0]     bit_idx_nxt;
    logic [DATA_BITS-1:0] shift_q;
    logic [DATA_BITS-1:0] shift_nxt;
    logic                 tone_d;
    logic                 start_evt;
    logic                 expiry;
    logic                 deliver;
    logic                 load_byte;
    logic                 fe_nxt;
    logic                 ov_nxt;

    fsk_tone_detect #(
        .CNT_W   (CNT_W),
        .THRESH  (THRESH),
        .MAX_HALF(MAX_HALF)
    ) u_tone (
        .clk    (clk),
        .resetb (resetb),
        .fsk_in (fsk_in),
        .tone   (tone),
        .carrier(carrier)
    );

    assign start_evt = tone_d & ~tone & carrier;
    assign expiry    = (timer == CNT_W'(1));

    always_comb begin
        // NOTE: every combinational output gets a default before the case so
        // no path leaves a signal unassigned and a latch cannot be inferred.
        state_nxt   = state;
        timer_nxt   = (timer != '0) ? timer - CNT_W'(1) : '0;
        bit_idx_nxt = bit_idx;
        shift_nxt   = shift_q;
        deliver     = 1'b0;
        fe_nxt      = 1'b0;

        if (!en) begin
            state_nxt   = IDLE;
            timer_nxt   = '0;
            bit_idx_nxt = '0;
            shift_nxt   = '0;
        end else if (state != IDLE && !carrier) begin
            state_nxt = IDLE;
            timer_nxt = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_evt) begin
                        timer_nxt = HALF_LOAD;
                        state_nxt = START;
                    end
                end
                START: begin
                    if (expiry) begin
                        if (!tone) begin
                            timer_nxt   = BIT_LOAD;
                            bit_idx_nxt = '0;
                            state_nxt   = DATA;
                        end else begin
                            state_nxt = IDLE;
                        end
                    end
                end
                DATA: begin
                    if (expiry) begin
                        shift_nxt[bit_idx] = tone;
                        timer_nxt          = BIT_LOAD;
                        if (bit_idx == IDX_W'(DATA_BITS - 1)) begin
                            state_nxt = STOP;
                        end else begin
                            bit_idx_nxt = bit_idx + IDX_W'(1);
                        end
                    end
                end
                STOP: begin
                    if (expiry) begin
                        deliver   = tone;
                        fe_nxt    = ~tone;
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // A completed byte lands unless the consumer is sitting on an unaccepted one.
    assign load_byte = deliver & (~rx_valid | rx_ready);
    assign ov_nxt    = deliver & rx_valid & ~rx_ready;

    always_ff @(posedge clk) begin
        if (!resetb) begin
            state     <= IDLE;
            timer     <= '0;
            bit_idx   <= '0;
            shift_q   <= '0;
            tone_d    <= 1'b1;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state     <= state_nxt;
            timer     <= timer_nxt;
            bit_idx   <= bit_idx_nxt;
            shift_q   <= shift_nxt;
            tone_d    <= tone;
            frame_err <= fe_nxt;
            overrun   <= ov_nxt;
            if (load_byte) begin
                rx_data  <= shift_q;
                rx_valid <= 1'b1;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule
